// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back vs. debug writes, with a
// timed drain before the port is handed to debug on halt.
module wb_port_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_wb_regwrite,
    input  logic [ADDR_WIDTH-1:0] i_wb_rd,
    input  logic [DATA_WIDTH-1:0] i_wb_data,
    input  logic                  i_halt_req,
    input  logic                  i_dbg_req,
    input  logic [ADDR_WIDTH-1:0] i_dbg_rd,
    input  logic [DATA_WIDTH-1:0] i_dbg_data,
    output logic                  o_dbg_ack,
    output logic                  o_halted,
    output logic                  o_rf_we,
    output logic [ADDR_WIDTH-1:0] o_rf_addr,
    output logic [DATA_WIDTH-1:0] o_rf_data,
    output logic [CNT_WIDTH-1:0]  o_wb_count
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED, S_DBG_ACK} state_e;

    state_e                state_q, state_d;
    logic [DW-1:0]         drain_q, drain_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  ack_q, ack_d;
    logic                  halted_q, halted_d;
    logic                  pipe_wr;

    // r0 is hard-wired zero, so writes to it never reach the register file
    assign pipe_wr = i_wb_regwrite && (i_wb_rd != '0);

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        count_d = count_q;

        if ((state_q == S_RUN || state_q == S_DRAIN) && pipe_wr) begin
            we_d    = 1'b1;
            addr_d  = i_wb_rd;
            data_d  = i_wb_data;
            count_d = count_q + CNT_WIDTH'(1);
        end

        case (state_q)
            S_RUN: begin
                if (i_halt_req) begin
                    state_d = S_DRAIN;
                    drain_d = DW'(DRAIN_CYCLES - 1);
                end
            end
            S_DRAIN: begin
                if (!i_halt_req)          state_d = S_RUN;
                else if (drain_q == '0)   state_d = S_HALTED;
                else                      drain_d = drain_q - DW'(1);
            end
            S_HALTED: begin
                // debug request wins over a same-cycle halt release
                if (i_dbg_req) begin
                    state_d = S_DBG_ACK;
                    if (i_dbg_rd != '0) begin
                        we_d   = 1'b1;
                        addr_d = i_dbg_rd;
                        data_d = i_dbg_data;
                    end
                end else if (!i_halt_req) begin
                    state_d = S_RUN;
                end
            end
            S_DBG_ACK: begin
                if (!i_dbg_req) state_d = S_HALTED;
            end
            default: state_d = S_RUN;
        endcase

        ack_d    = (state_d == S_DBG_ACK);
        halted_d = (state_d == S_HALTED) || (state_d == S_DBG_ACK);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= S_RUN;
            drain_q  <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            count_q  <= '0;
            ack_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            count_q  <= count_d;
            ack_q    <= ack_d;
            halted_q <= halted_d;
        end
    end

    assign o_rf_we    = we_q;
    assign o_rf_addr  = addr_q;
    assign o_rf_data  = data_q;
    assign o_wb_count = count_q;
    assign o_dbg_ack  = ack_q;
    assign o_halted   = halted_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios then random traffic, every cycle
// compared against a cycle-level behavioural model of the port-sharing rules.
module tb_wb_port_arbiter;

    localparam int DWID  = 32;
    localparam int AWID  = 5;
    localparam int DRAIN = 4;
    localparam int CW    = 8;   // narrow counter so the wrap is reached quickly

    logic            i_clk = 1'b0;
    logic            i_reset;
    logic            i_wb_regwrite;
    logic [AWID-1:0] i_wb_rd;
    logic [DWID-1:0] i_wb_data;
    logic            i_halt_req;
    logic            i_dbg_req;
    logic [AWID-1:0] i_dbg_rd;
    logic [DWID-1:0] i_dbg_data;
    logic            o_dbg_ack;
    logic            o_halted;
    logic            o_rf_we;
    logic [AWID-1:0] o_rf_addr;
    logic [DWID-1:0] o_rf_data;
    logic [CW-1:0]   o_wb_count;

    wb_port_arbiter #(.DATA_WIDTH(DWID), .ADDR_WIDTH(AWID), .DRAIN_CYCLES(DRAIN), .CNT_WIDTH(CW)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_wb_regwrite(i_wb_regwrite), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
        .i_halt_req(i_halt_req), .i_dbg_req(i_dbg_req), .i_dbg_rd(i_dbg_rd), .i_dbg_data(i_dbg_data),
        .o_dbg_ack(o_dbg_ack), .o_halted(o_halted), .o_rf_we(o_rf_we),
        .o_rf_addr(o_rf_addr), .o_rf_data(o_rf_data), .o_wb_count(o_wb_count)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;

    // behavioural model: phase flags plus a count of cycles spent draining
    bit        m_halted, m_acking, m_draining;
    int        m_drain_n;
    bit        e_we, e_ack, e_halted;
    bit [31:0] e_addr, e_data;
    int        e_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_halted = 0; m_acking = 0; m_draining = 0; m_drain_n = 0;
        e_we = 0; e_ack = 0; e_halted = 0; e_addr = 0; e_data = 0; e_cnt = 0;
    endtask

    task automatic model_step();
        e_we = 0;
        if (!m_halted) begin
            if (i_wb_regwrite && i_wb_rd != 0) begin
                e_we = 1; e_addr = 32'(i_wb_rd); e_data = i_wb_data;
                e_cnt = (e_cnt + 1) % (1 << CW);
            end
            if (!m_draining) begin
                if (i_halt_req) begin m_draining = 1; m_drain_n = 0; end
            end else if (!i_halt_req) begin
                m_draining = 0;
            end else begin
                m_drain_n++;
                if (m_drain_n == DRAIN) begin m_draining = 0; m_halted = 1; end
            end
        end else if (m_acking) begin
            if (!i_dbg_req) m_acking = 0;
        end else if (i_dbg_req) begin
            if (i_dbg_rd != 0) begin e_we = 1; e_addr = 32'(i_dbg_rd); e_data = i_dbg_data; end
            m_acking = 1;
        end else if (!i_halt_req) begin
            m_halted = 0;
        end
        e_ack = m_acking;
        e_halted = m_halted;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".we"},     32'(o_rf_we),    32'(e_we));
        chk({tag, ".addr"},   32'(o_rf_addr),  e_addr);
        chk({tag, ".data"},   o_rf_data,       e_data);
        chk({tag, ".count"},  32'(o_wb_count), 32'(e_cnt));
        chk({tag, ".ack"},    32'(o_dbg_ack),  32'(e_ack));
        chk({tag, ".halted"}, 32'(o_halted),   32'(e_halted));
    endtask

    task automatic tick(input string tag, input int n = 1);
        for (int k = 0; k < n; k++) begin
            model_step();
            @(posedge i_clk);
            #1;
            check_all(tag);
        end
    endtask

    // asserted between edges to confirm the reset is asynchronous
    task automatic do_reset(input string tag);
        i_reset = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(posedge i_clk);
        #1;
        check_all(tag);
        i_reset = 1'b1;
    endtask

    task automatic idle_inputs();
        i_wb_regwrite = 0; i_wb_rd = 0; i_wb_data = 0;
        i_halt_req = 0; i_dbg_req = 0; i_dbg_rd = 0; i_dbg_data = 0;
    endtask

    initial begin
        idle_inputs();
        i_reset = 1'b0;
        model_reset();
        #3;
        check_all("reset");
        @(posedge i_clk); #1;
        i_reset = 1'b1;
        tick("idle", 2);

        // 1: basic write, then an r0 write that must be suppressed
        i_wb_regwrite = 1; i_wb_rd = 5; i_wb_data = 32'hDEADBEEF;
        tick("wr5");
        i_wb_rd = 0; i_wb_data = 32'h0BADF00D;
        tick("wr0");
        i_wb_regwrite = 0;
        tick("idle1");

        // 2: halt entry while the pipeline keeps writing r3
        i_halt_req = 1; i_wb_regwrite = 1; i_wb_rd = 3;
        for (int k = 0; k < 9; k++) begin
            i_wb_data = 32'h3000 + 32'(k);
            tick("drain");
        end
        i_wb_regwrite = 0;

        // 3: one debug handshake with the request held for five cycles
        i_dbg_req = 1; i_dbg_rd = 7; i_dbg_data = 32'h12345678;
        tick("dbg", 5);
        i_dbg_req = 0;
        tick("dbgrel", 2);

        // 4: release from halt, then abort a drain after two cycles
        i_halt_req = 0;
        tick("unhalt", 2);
        i_wb_regwrite = 1; i_wb_rd = 9; i_wb_data = 32'hA5A5A5A5;
        i_halt_req = 1;
        tick("shortdrain", 3);
        i_halt_req = 0;
        tick("abort", 3);
        i_wb_regwrite = 0;

        // 5: debug request and halt release in the same cycle
        i_halt_req = 1;
        tick("halt5", 6);
        i_halt_req = 0; i_dbg_req = 1; i_dbg_rd = 11; i_dbg_data = 32'hCAFEF00D;
        tick("dbgprio", 3);
        i_dbg_req = 0;
        tick("dbgend", 3);

        // debug write to r0: acked but never written
        i_halt_req = 1;
        tick("halt0", 6);
        i_dbg_req = 1; i_dbg_rd = 0; i_dbg_data = 32'hFFFFFFFF;
        tick("dbgr0", 2);
        i_dbg_req = 0;
        tick("dbgr0rel", 1);
        i_halt_req = 0;
        tick("run0", 2);

        // 6: counter wrap, then reset in the middle of a handshake
        i_wb_regwrite = 1;
        for (int k = 0; k < (1 << CW) + 5; k++) begin
            i_wb_rd = AWID'($urandom_range(1, 31));
            i_wb_data = $urandom;
            tick("wrap");
        end
        i_wb_regwrite = 0;
        i_halt_req = 1;
        tick("halt6", 6);
        i_dbg_req = 1; i_dbg_rd = 4; i_dbg_data = 32'h44444444;
        tick("dbg6", 2);
        do_reset("rst_ack");
        idle_inputs();
        tick("postrst", 2);

        // random traffic with sticky halt/debug levels and occasional resets
        for (int k = 0; k < 3000; k++) begin
            i_wb_regwrite = ($urandom_range(0, 3) != 0);
            i_wb_rd = ($urandom_range(0, 7) == 0) ? AWID'(0) : AWID'($urandom);
            i_wb_data = $urandom;
            if ($urandom_range(0, 9) == 0) i_halt_req = ~i_halt_req;
            if ($urandom_range(0, 3) == 0) i_dbg_req = ~i_dbg_req;
            i_dbg_rd = ($urandom_range(0, 5) == 0) ? AWID'(0) : AWID'($urandom);
            i_dbg_data = $urandom;
            if ($urandom_range(0, 299) == 0) do_reset("rst_rand");
            else tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
